// File: rtl/sipo_frame_ctrl_pkg.sv
// Shared definitions for the SIPO frame controller: FSM encodings and default sizing.
package sipo_frame_ctrl_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int CNT_W_DEF = $clog2(WIDTH_DEF);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

endpackage

// File: rtl/sipo_frame_ctrl_frame_bit_counter.sv
// Modulo-WIDTH bit counter with sync clear, enable and terminal-count flag.
module frame_bit_counter
  import sipo_frame_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt;

  // Count enabled cycles, wrapping after the last bit position.
  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign tc = (cnt == LAST);

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frame sequencer for a serial-in/parallel-out shift register: drives Load for
// exactly WIDTH cycles per frame, captures the word and offers it on valid/ready.
module sipo_frame_ctrl
  import sipo_frame_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  output logic             Load,
  input  logic [WIDTH-1:0] Par_IN,
  output logic [WIDTH-1:0] Data_OUT,
  output logic             Data_Valid,
  input  logic             Data_Ready,
  output logic             Busy,
  output logic             Overrun,
  input  logic             Clr_Overrun
);

  state_t state;
  state_t state_nxt;
  logic   cnt_clr;
  logic   cnt_en;
  logic   bit_tc;
  logic   capture_ok;
  logic   capture_drop;

  // The counter restarts from zero every time SHIFT is entered.
  assign cnt_clr = (state != ST_SHIFT);
  assign cnt_en  = (state == ST_SHIFT);

  frame_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_cnt (
    .CLK (CLK),
    .RST (RST),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (bit_tc)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; Load and Busy depend on state only.
  always_comb begin
    state_nxt = state;
    Load      = 1'b0;
    Busy      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Start) begin
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        Load = 1'b1;
        Busy = 1'b1;
        if (bit_tc) begin
          state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        Busy      = 1'b1;
        state_nxt = Start ? ST_SHIFT : ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // A word is taken if the holding register is empty or being emptied now.
  assign capture_ok   = (state == ST_CAPTURE) && (!Data_Valid || Data_Ready);
  assign capture_drop = (state == ST_CAPTURE) && Data_Valid && !Data_Ready;

  // Holding register and valid flag; a same-cycle capture beats the transfer clear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      Data_OUT   <= '0;
      Data_Valid <= 1'b0;
    end else if (capture_ok) begin
      Data_OUT   <= Par_IN;
      Data_Valid <= 1'b1;
    end else if (Data_Valid && Data_Ready) begin
      Data_Valid <= 1'b0;
    end
  end

  // Sticky overrun flag; a new drop wins over a simultaneous clear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      Overrun <= 1'b0;
    end else if (capture_drop) begin
      Overrun <= 1'b1;
    end else if (Clr_Overrun) begin
      Overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Self-checking bench for sipo_frame_ctrl with a behavioural 4-bit SIPO on Load.
module tb_sipo_frame_ctrl;

  localparam int WIDTH = 4;

  logic             CLK = 1'b0;
  logic             RST;
  logic             Start;
  logic             Load;
  logic [WIDTH-1:0] Par_IN;
  logic [WIDTH-1:0] Data_OUT;
  logic             Data_Valid;
  logic             Data_Ready;
  logic             Busy;
  logic             Overrun;
  logic             Clr_Overrun;

  logic             sin = 1'b0;
  logic [WIDTH-1:0] sr = '0;

  logic             bit_q[$];
  logic [WIDTH-1:0] exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  sipo_frame_ctrl #(.WIDTH(WIDTH)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .Start       (Start),
    .Load        (Load),
    .Par_IN      (Par_IN),
    .Data_OUT    (Data_OUT),
    .Data_Valid  (Data_Valid),
    .Data_Ready  (Data_Ready),
    .Busy        (Busy),
    .Overrun     (Overrun),
    .Clr_Overrun (Clr_Overrun)
  );

  always #5 CLK = ~CLK;

  // Behavioural SIPO: serial bit enters the MSB and moves toward the LSB.
  always @(posedge CLK) begin
    if (Load) sr <= {sin, sr[WIDTH-1:1]};
  end
  assign Par_IN = sr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Queue serial bits (first bit first); the delivered word has bit k in position k.
  task automatic push_frame(input logic b0, input logic b1, input logic b2,
                            input logic b3, input bit deliver);
    bit_q.push_back(b0);
    bit_q.push_back(b1);
    bit_q.push_back(b2);
    bit_q.push_back(b3);
    if (deliver) exp_q.push_back({b3, b2, b1, b0});
  endtask

  // Present the next serial bit while the shifter is enabled.
  always @(negedge CLK) begin
    if (Load && bit_q.size() > 0) sin = bit_q.pop_front();
  end

  // Scoreboard: every handshake transfer must deliver the oldest expected word.
  always @(negedge CLK) begin
    if (!RST && Data_Valid && Data_Ready) begin
      if (exp_q.size() == 0) chk("sb_underflow", 32'(Data_OUT), 32'hFFFF_FFFF);
      else                   chk("sb_word", 32'(Data_OUT), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    int load_cnt;
    int dv_first;
    int dv_cnt;
    int busy_lo;
    int p1;
    int p2;
    logic dv_prev;

    RST = 1'b1; Start = 1'b0; Data_Ready = 1'b0; Clr_Overrun = 1'b0;
    tick(); tick();
    RST = 1'b0;
    repeat (5) tick();
    chk("rst_load",  32'(Load), 32'd0);
    chk("rst_busy",  32'(Busy), 32'd0);
    chk("rst_valid", 32'(Data_Valid), 32'd0);
    chk("rst_ovr",   32'(Overrun), 32'd0);
    chk("rst_data",  32'(Data_OUT), 32'h0);

    // Single frame 1,0,1,1 with consumer ready.
    Data_Ready = 1'b1;
    push_frame(1, 0, 1, 1, 1);
    Start = 1'b1; tick(); Start = 1'b0;
    load_cnt = 0; dv_first = -1; dv_cnt = 0;
    for (int n = 0; n < 8; n++) begin
      if (Load) load_cnt++;
      if (Data_Valid) begin
        dv_cnt++;
        if (dv_first < 0) dv_first = n;
      end
      if (n == 5) chk("single_data", 32'(Data_OUT), 32'hD);
      tick();
    end
    chk("single_load_cycles", 32'(load_cnt), 32'd4);
    chk("single_dv_latency",  32'(dv_first), 32'd5);
    chk("single_dv_cycles",   32'(dv_cnt), 32'd1);

    // Back-to-back frames with Start held high.
    push_frame(1, 1, 0, 0, 1);
    push_frame(0, 1, 0, 1, 1);
    Start = 1'b1; tick();
    busy_lo = 0; p1 = -1; p2 = -1; dv_prev = Data_Valid;
    for (int n = 0; n < 13; n++) begin
      if (n <= 9 && !Busy) busy_lo++;
      if (Data_Valid && !dv_prev) begin
        if (p1 < 0) p1 = n;
        else if (p2 < 0) p2 = n;
      end
      dv_prev = Data_Valid;
      if (n == 5) Start = 1'b0;
      tick();
    end
    chk("b2b_busy_gap", 32'(busy_lo), 32'd0);
    chk("b2b_dv_first", 32'(p1), 32'd5);
    chk("b2b_dv_second", 32'(p2), 32'd10);
    chk("b2b_idle_after", 32'(Busy), 32'd0);

    // Consumer stalled: second word dropped, first retained.
    Data_Ready = 1'b0;
    push_frame(1, 1, 0, 0, 1);
    push_frame(0, 1, 1, 0, 0);
    Start = 1'b1; tick();
    for (int n = 0; n < 11; n++) begin
      if (n == 9) chk("ovr_before_drop", 32'(Overrun), 32'd0);
      if (n == 5) Start = 1'b0;
      tick();
    end
    chk("ovr_set",      32'(Overrun), 32'd1);
    chk("ovr_valid",    32'(Data_Valid), 32'd1);
    chk("ovr_retained", 32'(Data_OUT), 32'h3);
    Clr_Overrun = 1'b1; tick(); Clr_Overrun = 1'b0;
    chk("ovr_clear", 32'(Overrun), 32'd0);

    // Clear held across a new drop: the set must win.
    push_frame(1, 1, 1, 1, 0);
    Clr_Overrun = 1'b1; Start = 1'b1; tick(); Start = 1'b0;
    repeat (5) tick();
    chk("ovr_set_wins",  32'(Overrun), 32'd1);
    chk("ovr_retained2", 32'(Data_OUT), 32'h3);
    Clr_Overrun = 1'b0;
    tick();
    chk("ovr_sticky", 32'(Overrun), 32'd1);
    Clr_Overrun = 1'b1; tick(); Clr_Overrun = 1'b0;
    chk("ovr_clear2", 32'(Overrun), 32'd0);

    // Ready only on the capture cycle: transfer and capture coincide.
    push_frame(1, 0, 0, 1, 1);
    Start = 1'b1; tick(); Start = 1'b0;
    repeat (4) tick();
    chk("cap_state_busy", 32'(Busy), 32'd1);
    Data_Ready = 1'b1; tick(); Data_Ready = 1'b0;
    chk("cap_valid_kept", 32'(Data_Valid), 32'd1);
    chk("cap_new_data",   32'(Data_OUT), 32'h9);
    chk("cap_no_ovr",     32'(Overrun), 32'd0);
    tick();
    chk("cap_data_stable", 32'(Data_OUT), 32'h9);
    Data_Ready = 1'b1; tick(); Data_Ready = 1'b0;
    chk("cap_drained", 32'(Data_Valid), 32'd0);

    // Reset during the second shift cycle aborts the frame.
    Data_Ready = 1'b1;
    push_frame(1, 1, 1, 1, 0);
    Start = 1'b1; tick(); Start = 1'b0;
    tick();
    RST = 1'b1; tick(); RST = 1'b0;
    bit_q.delete();
    chk("abort_load",  32'(Load), 32'd0);
    chk("abort_busy",  32'(Busy), 32'd0);
    chk("abort_valid", 32'(Data_Valid), 32'd0);
    repeat (4) tick();
    chk("abort_no_capture", 32'(Data_Valid), 32'd0);

    push_frame(0, 0, 0, 1, 1);
    Start = 1'b1; tick(); Start = 1'b0;
    repeat (5) tick();
    chk("post_abort_valid", 32'(Data_Valid), 32'd1);
    chk("post_abort_data",  32'(Data_OUT), 32'h8);
    repeat (2) tick();
    Data_Ready = 1'b0;

    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sipo_frame_ctrl.md
Name: sipo_frame_ctrl

Overview:
- Sequencing controller for a WIDTH-bit serial-in/parallel-out shift register built from mux-gated DFF stages. Load=1 shifts; Load=0 holds.
- On a frame-start pulse, asserts Load for exactly WIDTH cycles and counts the bits.
- Then captures the register's parallel output into a holding register and offers it downstream with a valid/ready handshake.
- Sits between the serial front end and the word-level consumer, and flags overruns.

Parameters:
- WIDTH, 4, shift-register length and word width in bits (>=2).
- CNT_W, $clog2(WIDTH), bit-counter width.

Ports:
- CLK  input  1  system clock; all logic on its rising edge.
- RST  input  1  synchronous, active-high reset.
- Start  input  1  frame-start request, sampled each cycle.
- Load  output  1  shift enable to the SIPO Load pin.
- Par_IN  input  WIDTH  parallel OUT of the SIPO.
- Data_OUT  output  WIDTH  captured word.
- Data_Valid  output  1  Data_OUT holds an unconsumed word.
- Data_Ready  input  1  consumer accepts Data_OUT this cycle.
- Busy  output  1  frame in progress (state != IDLE).
- Overrun  output  1  sticky; a captured word was dropped.
- Clr_Overrun  input  1  clears Overrun.

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high. It overrides everything.
- Reset values: state=IDLE, bit_cnt=0, Load=0, Busy=0, Data_OUT=0, Data_Valid=0, Overrun=0.
- Reset mid-frame aborts the frame with no capture. The SIPO itself has no reset; its stale contents are harmless because every frame shifts all WIDTH bits.
- Load and Busy are Moore outputs decoded from state. Load = (state==SHIFT). No glitch path from inputs.
- FSM states: IDLE, SHIFT, CAPTURE.
  - IDLE: on Start=1, go to SHIFT with bit_cnt<=0. Otherwise stay.
  - SHIFT: bit_cnt increments every cycle. When bit_cnt==WIDTH-1, go to CAPTURE. Load is therefore high for exactly WIDTH consecutive edges. Start is ignored in SHIFT.
  - CAPTURE: Par_IN now holds the complete word. Perform the capture rule below. Then go to SHIFT (bit_cnt<=0) if Start=1 (back-to-back frames), else go to IDLE.
- Timing: Start sampled at edge E0. Shift edges are E1..E_WIDTH. Serial bit k (k=0 first) must be stable before edge E(k+1).
- Bit order: the serial input enters the MSB stage and moves toward the LSB. The first bit ends in Par_IN[0]; the last bit ends in Par_IN[WIDTH-1].
- Capture happens at edge E(WIDTH+1). Data_Valid is first high after that edge. Latency from Start to Data_Valid is WIDTH+1 cycles. Minimum frame period is WIDTH+1 cycles.
- Capture rule, in CAPTURE:
  - If Data_Valid==0, or Data_Valid==1 with Data_Ready==1 in the same cycle: Data_OUT<=Par_IN and Data_Valid<=1.
  - Otherwise the word is dropped, Data_OUT is unchanged, and Overrun<=1.
- Handshake:
  - Transfer occurs when Data_Valid & Data_Ready.
  - Data_Valid clears on a transfer, except when a capture happens in the same cycle; then it stays 1 with the new data.
  - Data_OUT is stable while Data_Valid=1 and no transfer occurs.
  - Data_Ready while Data_Valid=0 has no effect.
- Overrun: set as above. Cleared by Clr_Overrun. If set and clear occur in the same cycle, set wins.
- Start held high continuously produces back-to-back frames, one every WIDTH+1 cycles.

Decomposition:
- Shared header/package holds: state encodings (ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_CAPTURE=2'd2), the WIDTH default, and the CNT_W derivation.
- Natural sub-module: frame_bit_counter. Modulo-WIDTH up-counter with sync clear, enable and terminal-count output (tc = cnt==WIDTH-1).
- FSM and output register stay in sipo_frame_ctrl.
- The bench instantiates the existing 4-bit SIPO (or a behavioural equivalent) driven by Load.

Test Plan (all with WIDTH=4):
- Reset, then idle 5 cycles -> Load=0, Busy=0, Data_Valid=0, Overrun=0, Data_OUT=4'h0.
- Start pulse, serial bits 1,0,1,1, Data_Ready=1 -> Load high exactly 4 cycles. Data_Valid high 5 cycles after Start with Data_OUT=4'b1101. Data_Valid drops the following cycle.
- Start held high, frames 1,1,0,0 then 0,1,0,1, Data_Ready=1 -> words 4'b0011 then 4'b1010, Data_Valid pulses 5 cycles apart, Busy never drops between frames.
- Data_Ready=0, two frames -> first word 4'b0011 retained, Overrun=1 after the second capture. Clr_Overrun clears it. Clr_Overrun in the same cycle as a new overrun leaves Overrun=1.
- Data_Ready=1 exactly on the second frame's capture cycle -> the first word is transferred, Data_OUT updates to the second word, Data_Valid stays 1, Overrun stays 0.
- RST asserted at the 2nd shift cycle -> next cycle Load=0, Busy=0, no Data_Valid. A following full frame 0,0,0,1 yields 4'b1000.
